// File: rtl/lutram_arb_pkg.sv
// Shared types and defaults for the lutram port arbiter slice.
// Holds the arbiter state encoding, the default geometry and the ID-width helper.
package lutram_arb_pkg;

  localparam int DEFAULT_ELEMENT_BITS = 64;
  localparam int DEFAULT_NUMBER_SETS  = 64;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_FLUSH = 1'b1
  } arb_state_e;

  // A single client still needs a 1-bit ID field.
  function automatic int id_width(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first valid client at or above the pointer, with wrap.
module rr_priority_picker
  import lutram_arb_pkg::*;
#(
  parameter int NUM_REQUESTERS = 4,
  parameter int REQ_ID_WIDTH   = id_width(NUM_REQUESTERS)
) (
  input  logic [NUM_REQUESTERS-1:0] valid_in,
  input  logic [REQ_ID_WIDTH-1:0]   pointer_in,
  output logic [NUM_REQUESTERS-1:0] grant_out,
  output logic [REQ_ID_WIDTH-1:0]   grant_id_out,
  output logic                      grant_any_out
);

  logic [REQ_ID_WIDTH-1:0] candidate_s;
  logic                    hit_s;

  // Walk the clients in priority order; the first hit locks out the rest.
  always_comb begin
    grant_out     = {NUM_REQUESTERS{1'b0}};
    grant_id_out  = {REQ_ID_WIDTH{1'b0}};
    grant_any_out = 1'b0;
    candidate_s   = {REQ_ID_WIDTH{1'b0}};
    hit_s         = 1'b0;
    for (int k = 0; k < NUM_REQUESTERS; k++) begin
      candidate_s   = REQ_ID_WIDTH'((int'(pointer_in) + k) % NUM_REQUESTERS);
      hit_s         = valid_in[candidate_s] & ~grant_any_out;
      grant_out     = grant_out | ({{(NUM_REQUESTERS-1){1'b0}}, hit_s} << candidate_s);
      grant_id_out  = hit_s ? candidate_s : grant_id_out;
      grant_any_out = grant_any_out | hit_s;
    end
  end

endmodule

// File: rtl/single_port_lutram.sv
// Distributed-RAM style single-port storage with a registered, read-before-write output.
// The active-high reset clears the contents.
module single_port_lutram #(
  parameter int SINGLE_ELEMENT_SIZE_IN_BITS = 64,
  parameter int NUMBER_SETS                 = 64,
  parameter int SET_PTR_WIDTH_IN_BITS       = $clog2(NUMBER_SETS)
) (
  input  logic                                   clk_in,
  input  logic                                   reset_in,
  input  logic                                   access_en_in,
  input  logic                                   write_en_in,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]       access_set_addr_in,
  input  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] write_element_in,
  output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] read_element_out
);

  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] mem_r [NUMBER_SETS];

  // Storage array and registered read port; a write returns the prior contents.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      for (int s = 0; s < NUMBER_SETS; s++) begin
        mem_r[s] <= {SINGLE_ELEMENT_SIZE_IN_BITS{1'b0}};
      end
      read_element_out <= {SINGLE_ELEMENT_SIZE_IN_BITS{1'b0}};
    end else if (access_en_in) begin
      read_element_out <= mem_r[access_set_addr_in];
      if (write_en_in) begin
        mem_r[access_set_addr_in] <= write_element_in;
      end
    end
  end

endmodule

// File: rtl/lutram_port_arbiter.sv
// Shares one single_port_lutram between several clients with round-robin arbitration,
// one-cycle tagged responses and a runtime flush that zeroes every set.
module lutram_port_arbiter
  import lutram_arb_pkg::*;
#(
  parameter int SINGLE_ELEMENT_SIZE_IN_BITS = DEFAULT_ELEMENT_BITS,
  parameter int NUMBER_SETS                 = DEFAULT_NUMBER_SETS,
  parameter int SET_PTR_WIDTH_IN_BITS       = $clog2(NUMBER_SETS),
  parameter int NUM_REQUESTERS              = 4,
  parameter int REQ_ID_WIDTH                = id_width(NUM_REQUESTERS)
) (
  input  logic                                                clk_in,
  input  logic                                                reset_in,
  input  logic                                                flush_req_in,
  output logic                                                flush_busy_out,
  input  logic [NUM_REQUESTERS-1:0]                           req_valid_in,
  input  logic [NUM_REQUESTERS-1:0]                           req_write_in,
  input  logic [NUM_REQUESTERS*SET_PTR_WIDTH_IN_BITS-1:0]       req_addr_in,
  input  logic [NUM_REQUESTERS*SINGLE_ELEMENT_SIZE_IN_BITS-1:0] req_data_in,
  output logic [NUM_REQUESTERS-1:0]                           req_ready_out,
  output logic                                                resp_valid_out,
  output logic [REQ_ID_WIDTH-1:0]                             resp_id_out,
  output logic                                                resp_write_out,
  output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0]              resp_data_out
);

  localparam int EW = SINGLE_ELEMENT_SIZE_IN_BITS;
  localparam int AW = SET_PTR_WIDTH_IN_BITS;
  localparam int NR = NUM_REQUESTERS;
  localparam int IW = REQ_ID_WIDTH;

  arb_state_e    state_r, state_next_s;
  logic [IW-1:0] pointer_r;
  logic [AW-1:0] flush_cnt_r;
  logic          flush_last_s;
  logic [NR-1:0] eligible_s, grant_s;
  logic [IW-1:0] grant_id_s;
  logic          grant_any_s;
  logic          resp_valid_r, resp_write_r;
  logic [IW-1:0] resp_id_r;
  logic          lut_en_s, lut_we_s;
  logic [AW-1:0] lut_addr_s;
  logic [EW-1:0] lut_wdata_s, lut_rdata_s;
  logic [AW-1:0] addr_slice_s [NR];
  logic [EW-1:0] data_slice_s [NR];

  for (genvar g = 0; g < NR; g++) begin : g_unpack
    assign addr_slice_s[g] = req_addr_in[g*AW +: AW];
    assign data_slice_s[g] = req_data_in[g*EW +: EW];
  end

  // A flush pulse in IDLE blocks arbitration for that cycle.
  assign eligible_s   = (state_r == ARB_IDLE && !flush_req_in) ? req_valid_in : {NR{1'b0}};
  assign flush_last_s = (flush_cnt_r == AW'(NUMBER_SETS - 1));

  rr_priority_picker #(
    .NUM_REQUESTERS (NR),
    .REQ_ID_WIDTH   (IW)
  ) u_picker (
    .valid_in      (eligible_s),
    .pointer_in    (pointer_r),
    .grant_out     (grant_s),
    .grant_id_out  (grant_id_s),
    .grant_any_out (grant_any_s)
  );

  // Next-state logic for the IDLE/FLUSH sequencer.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ARB_IDLE:  if (flush_req_in) state_next_s = ARB_FLUSH; else state_next_s = ARB_IDLE;
      ARB_FLUSH: if (flush_last_s) state_next_s = ARB_IDLE;  else state_next_s = ARB_FLUSH;
      default:   state_next_s = ARB_IDLE;
    endcase
  end

  // Storage port mux: flush zero-writes take precedence over client grants.
  always_comb begin
    lut_en_s    = 1'b0;
    lut_we_s    = 1'b0;
    lut_addr_s  = {AW{1'b0}};
    lut_wdata_s = {EW{1'b0}};
    if (state_r == ARB_FLUSH) begin
      lut_en_s   = 1'b1;
      lut_we_s   = 1'b1;
      lut_addr_s = flush_cnt_r;
    end else if (grant_any_s) begin
      lut_en_s    = 1'b1;
      lut_we_s    = req_write_in[grant_id_s];
      lut_addr_s  = addr_slice_s[grant_id_s];
      lut_wdata_s = data_slice_s[grant_id_s];
    end else begin
      lut_en_s = 1'b0;
    end
  end

  // Sequencer state, round-robin pointer, flush counter and response tags.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state_r      <= ARB_IDLE;
      pointer_r    <= {IW{1'b0}};
      flush_cnt_r  <= {AW{1'b0}};
      resp_valid_r <= 1'b0;
      resp_id_r    <= {IW{1'b0}};
      resp_write_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      if (grant_any_s) begin
        pointer_r <= (grant_id_s == IW'(NR - 1)) ? {IW{1'b0}} : grant_id_s + IW'(1);
      end
      if (state_r == ARB_FLUSH && !flush_last_s) begin
        flush_cnt_r <= flush_cnt_r + AW'(1);
      end else begin
        flush_cnt_r <= {AW{1'b0}};
      end
      resp_valid_r <= grant_any_s;
      resp_id_r    <= grant_any_s ? grant_id_s : {IW{1'b0}};
      resp_write_r <= grant_any_s & req_write_in[grant_id_s];
    end
  end

  single_port_lutram #(
    .SINGLE_ELEMENT_SIZE_IN_BITS (EW),
    .NUMBER_SETS                 (NUMBER_SETS),
    .SET_PTR_WIDTH_IN_BITS       (AW)
  ) u_lutram (
    .clk_in             (clk_in),
    .reset_in           (~reset_in),
    .access_en_in       (lut_en_s),
    .write_en_in        (lut_we_s),
    .access_set_addr_in (lut_addr_s),
    .write_element_in   (lut_wdata_s),
    .read_element_out   (lut_rdata_s)
  );

  assign req_ready_out  = grant_s;
  assign flush_busy_out = (state_r == ARB_FLUSH);
  assign resp_valid_out = resp_valid_r;
  assign resp_id_out    = resp_id_r;
  assign resp_write_out = resp_write_r;
  assign resp_data_out  = resp_valid_r ? lut_rdata_s : {EW{1'b0}};

endmodule

// File: tb/tb_lutram_port_arbiter.sv
// Scoreboard bench for lutram_port_arbiter: directed stimulus pushes expected responses,
// an independent monitor pops and compares whenever a response is presented.
module tb_lutram_port_arbiter;

  localparam int EW = 64;
  localparam int NS = 64;
  localparam int AW = 6;
  localparam int NR = 4;
  localparam int IW = 2;

  logic             clk_in = 1'b0;
  logic             reset_in = 1'b1;
  logic             flush_req_in;
  logic             flush_busy_out;
  logic [NR-1:0]    req_valid_in, req_write_in, req_ready_out;
  logic [NR*AW-1:0] req_addr_in;
  logic [NR*EW-1:0] req_data_in;
  logic             resp_valid_out, resp_write_out;
  logic [IW-1:0]    resp_id_out;
  logic [EW-1:0]    resp_data_out;

  typedef struct packed {
    logic [IW-1:0] id;
    logic          wr;
    logic [EW-1:0] data;
  } resp_t;

  resp_t exp_q[$];
  resp_t mon_r;
  int    n_checks = 0;
  int    n_fail   = 0;

  lutram_port_arbiter #(
    .SINGLE_ELEMENT_SIZE_IN_BITS (EW),
    .NUMBER_SETS                 (NS),
    .SET_PTR_WIDTH_IN_BITS       (AW),
    .NUM_REQUESTERS              (NR),
    .REQ_ID_WIDTH                (IW)
  ) dut (
    .clk_in         (clk_in),
    .reset_in       (reset_in),
    .flush_req_in   (flush_req_in),
    .flush_busy_out (flush_busy_out),
    .req_valid_in   (req_valid_in),
    .req_write_in   (req_write_in),
    .req_addr_in    (req_addr_in),
    .req_data_in    (req_data_in),
    .req_ready_out  (req_ready_out),
    .resp_valid_out (resp_valid_out),
    .resp_id_out    (resp_id_out),
    .resp_write_out (resp_write_out),
    .resp_data_out  (resp_data_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic w,
                         input logic [AW-1:0] a, input logic [EW-1:0] d);
    req_valid_in[i]        = v;
    req_write_in[i]        = w;
    req_addr_in[i*AW +: AW] = a;
    req_data_in[i*EW +: EW] = d;
  endtask

  // Check the grant vector this cycle; a granted client's response is expected next cycle.
  task automatic expect_grant(input int id, input logic w, input logic [EW-1:0] d);
    logic [NR-1:0] g;
    g = (id < 0) ? 4'b0000 : (4'b0001 << id);
    #1;
    check("req_ready", 64'(req_ready_out), 64'(g));
    if (id >= 0) exp_q.push_back({IW'(id), w, d});
  endtask

  task automatic idle_cycle();
    @(negedge clk_in);
    req_valid_in = 4'b0000;
    flush_req_in = 1'b0;
    expect_grant(-1, 1'b0, 64'h0);
  endtask

  // Monitor: compare every presented response against the scoreboard head.
  always begin
    @(posedge clk_in);
    #2;
    if (resp_valid_out) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL resp_unexpected: got id %0d data %0h, expected no response", resp_id_out, resp_data_out);
      end else begin
        mon_r = exp_q.pop_front();
        check("resp_id", 64'(resp_id_out), 64'(mon_r.id));
        check("resp_write", 64'(resp_write_out), 64'(mon_r.wr));
        check("resp_data", resp_data_out, mon_r.data);
      end
    end else begin
      check("resp_data_idle", resp_data_out, 64'h0);
    end
  end

  initial begin
    flush_req_in = 1'b0;
    req_valid_in = 4'b0000;
    req_write_in = 4'b0000;
    req_addr_in  = '0;
    req_data_in  = '0;
    #1 reset_in  = 1'b0;
    repeat (3) @(negedge clk_in);
    #1;
    check("rst_flush_busy", 64'(flush_busy_out), 64'h0);
    check("rst_resp_valid", 64'(resp_valid_out), 64'h0);
    check("rst_resp_id", 64'(resp_id_out), 64'h0);
    check("rst_resp_write", 64'(resp_write_out), 64'h0);
    check("rst_req_ready", 64'(req_ready_out), 64'h0);
    @(negedge clk_in);
    reset_in = 1'b1;

    // All four clients writing continuously: grants 0,1,2,3,0.
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_in);
      for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b1, AW'(20 + i), 64'h100 + 64'(i));
      expect_grant(c % NR, 1'b1, (c == 4) ? 64'h100 : 64'h0);
    end
    idle_cycle();

    // Client 1 writes 0xAAAA to set 5, then reads it back.
    @(negedge clk_in);
    set_req(1, 1'b1, 1'b1, 6'd5, 64'hAAAA);
    expect_grant(1, 1'b1, 64'h0);
    @(negedge clk_in);
    set_req(1, 1'b1, 1'b0, 6'd5, 64'h0);
    expect_grant(1, 1'b0, 64'hAAAA);
    idle_cycle();

    // Only client 3 valid for 10 cycles; pointer wraps to 0 each time.
    req_valid_in = 4'b0000;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_in);
      set_req(3, 1'b1, 1'b0, 6'd5, 64'h0);
      expect_grant(3, 1'b0, 64'hAAAA);
    end
    @(negedge clk_in);
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b0, 6'd5, 64'h0);
    expect_grant(0, 1'b0, 64'hAAAA);
    idle_cycle();

    // Write 0x1234 to sets 0 and 63, then flush with client 2 waiting.
    @(negedge clk_in);
    set_req(0, 1'b1, 1'b1, 6'd0, 64'h1234);
    expect_grant(0, 1'b1, 64'h0);
    @(negedge clk_in);
    req_valid_in = 4'b0000;
    set_req(1, 1'b1, 1'b1, 6'd63, 64'h1234);
    expect_grant(1, 1'b1, 64'h0);
    @(negedge clk_in);
    req_valid_in = 4'b0000;
    flush_req_in = 1'b1;
    set_req(2, 1'b1, 1'b0, 6'd0, 64'h0);
    expect_grant(-1, 1'b0, 64'h0);
    check("flush_busy_pulse", 64'(flush_busy_out), 64'h0);
    for (int k = 1; k <= NS; k++) begin
      @(negedge clk_in);
      flush_req_in = (k == 10);
      expect_grant(-1, 1'b0, 64'h0);
      check("flush_busy_high", 64'(flush_busy_out), 64'h1);
    end
    @(negedge clk_in);
    flush_req_in = 1'b0;
    expect_grant(2, 1'b0, 64'h0);
    check("flush_busy_done", 64'(flush_busy_out), 64'h0);
    @(negedge clk_in);
    req_valid_in = 4'b0000;
    set_req(1, 1'b1, 1'b0, 6'd63, 64'h0);
    expect_grant(1, 1'b0, 64'h0);
    @(negedge clk_in);
    req_valid_in = 4'b0000;
    set_req(0, 1'b1, 1'b0, 6'd20, 64'h0);
    expect_grant(0, 1'b0, 64'h0);
    idle_cycle();

    // Write set 40, flush, then reset when the flush counter reaches 20.
    @(negedge clk_in);
    set_req(2, 1'b1, 1'b1, 6'd40, 64'hBEEF);
    expect_grant(2, 1'b1, 64'h0);
    @(negedge clk_in);
    req_valid_in = 4'b0000;
    flush_req_in = 1'b1;
    expect_grant(-1, 1'b0, 64'h0);
    for (int k = 1; k <= 21; k++) begin
      @(negedge clk_in);
      flush_req_in = 1'b0;
      expect_grant(-1, 1'b0, 64'h0);
    end
    reset_in = 1'b0;
    #1;
    check("midrst_flush_busy", 64'(flush_busy_out), 64'h0);
    check("midrst_resp_valid", 64'(resp_valid_out), 64'h0);
    check("midrst_resp_id", 64'(resp_id_out), 64'h0);
    check("midrst_resp_write", 64'(resp_write_out), 64'h0);
    check("midrst_resp_data", resp_data_out, 64'h0);
    check("midrst_req_ready", 64'(req_ready_out), 64'h0);
    @(negedge clk_in);
    reset_in = 1'b1;
    @(negedge clk_in);
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b0, 6'd40, 64'h0);
    expect_grant(0, 1'b0, 64'h0);
    idle_cycle();
    repeat (3) idle_cycle();

    check("scoreboard_drained", 64'(exp_q.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
